button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 164 ++++++++++++++++
 tb/tb_button_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the three raw push-buttons (left, right, fire). Each button is
//   synchronized, debounced into a clean level, and turned into one-cycle
//   action pulses. Left/right pulse on press and auto-repeat while held; fire
//   pulses once per press. At most one action pulse is high in any cycle.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   btnL_in/R_in/U_in   raw asynchronous button inputs, active-high
//   left/right/fire_level  debounced button levels
//   left_move/right_move   press + auto-repeat pulses
//   fire                   press-only pulse
//
// Repeat FSM (one per move button)
//   state      | meaning
//   REP_DELAY  | waiting REPEAT_DELAY cycles after the press pulse
//   REP_PERIOD | emitting a repeat every REPEAT_PERIOD cycles
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int REPEAT_DELAY    = 3125000,
    parameter int REPEAT_PERIOD   = 625000,
    parameter int CNT_W           = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic btnL_in,
    input  logic btnR_in,
    input  logic btnU_in,
    output logic left_level,
    output logic right_level,
    output logic fire_level,
    output logic left_move,
    output logic right_move,
    output logic fire
);

    typedef enum logic {REP_DELAY = 1'b0, REP_PERIOD = 1'b1} repState_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit index: 0 = left, 1 = right, 2 = fire
    logic [2:0]       syncA, syncB;
    logic [2:0]       level, levelNext, rise;
    logic [1:0]       fall;
    logic [CNT_W-1:0] dcnt [3];
    logic [CNT_W-1:0] dcntNext [3];

    repState_t        repState [2];
    repState_t        repStateNext [2];
    logic [CNT_W-1:0] rcnt [2];
    logic [CNT_W-1:0] rcntNext [2];
    logic [1:0]       repEvent;

    logic exclL, exclR;

    // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            levelNext[i] = level[i];
            dcntNext[i]  = '0;
            if (syncB[i] != level[i]) begin
                if (dcnt[i] == DEB_LAST) begin
                    levelNext[i] = syncB[i];
                end else begin
                    dcntNext[i] = dcnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign rise = levelNext & ~level;
    assign fall = level[1:0] & ~levelNext[1:0];

    // Exclusivity looks at next-state levels so the registered pulses line
    // up with the registered levels.
    assign exclL = levelNext[0] & ~levelNext[1] & ~levelNext[2];
    assign exclR = levelNext[1] & ~levelNext[0] & ~levelNext[2];

    // The repeat timer runs regardless of exclusivity; suppressed events are
    // simply lost.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            repStateNext[i] = repState[i];
            rcntNext[i]     = rcnt[i];
            repEvent[i]     = 1'b0;
            if (rise[i] || fall[i]) begin
                repStateNext[i] = REP_DELAY;
                rcntNext[i]     = '0;
            end else if (level[i]) begin
                case (repState[i])
                    REP_DELAY: begin
                        if (rcnt[i] == DLY_LAST) begin
                            repEvent[i]     = 1'b1;
                            rcntNext[i]     = '0;
                            repStateNext[i] = REP_PERIOD;
                        end else begin
                            rcntNext[i] = rcnt[i] + CNT_ONE;
                        end
                    end
                    REP_PERIOD: begin
                        if (rcnt[i] == PER_LAST) begin
                            repEvent[i] = 1'b1;
                            rcntNext[i] = '0;
                        end else begin
                            rcntNext[i] = rcnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        repStateNext[i] = REP_DELAY;
                        rcntNext[i]     = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                repState[i] <= REP_DELAY;
                rcnt[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                repState[i] <= repStateNext[i];
                rcnt[i]     <= rcntNext[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncA      <= '0;
            syncB      <= '0;
            level      <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
            left_move  <= 1'b0;
            right_move <= 1'b0;
            fire       <= 1'b0;
        end else begin
            syncA      <= {btnU_in, btnR_in, btnL_in};
            syncB      <= syncA;
            level      <= levelNext;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= dcntNext[i];
            end
            left_move  <= (rise[0] | repEvent[0]) & exclL;
            right_move <= (rise[1] | repEvent[1]) & exclR;
            fire       <= rise[2] & ~levelNext[0] & ~levelNext[1];
        end
    end

    assign left_level  = level[0];
    assign right_level = level[1];
    assign fire_level  = level[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: table-driven scenario rows with hand
// derived expectations, hand-written corner sequences, and a randomized run,
// all cross-checked every cycle against a behavioural reference model.
module tb_button_conditioner;

    localparam int DEB     = 4;
    localparam int RDELAY  = 10;
    localparam int RPERIOD = 5;
    localparam int CW      = 8;

    logic clk = 1'b0;
    logic reset;
    logic btnL_in, btnR_in, btnU_in;
    logic left_level, right_level, fire_level;
    logic left_move, right_move, fire;

    int tests  = 0;
    int failed = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPERIOD),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btnL_in    (btnL_in),
        .btnR_in    (btnR_in),
        .btnU_in    (btnU_in),
        .left_level (left_level),
        .right_level(right_level),
        .fire_level (fire_level),
        .left_move  (left_move),
        .right_move (right_move),
        .fire       (fire)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A level toggles once the last DEB synchronized samples all disagree
    // with it; repeats are placed arithmetically from the press cycle.
    bit s1 [3];
    bit s2 [3];
    bit lvl [3];
    bit hist [3][$];
    int pressT [2];
    int cyc;
    bit expL, expR, expF;

    function automatic void modelReset();
        for (int i = 0; i < 3; i++) begin
            s1[i] = 0; s2[i] = 0; lvl[i] = 0;
            hist[i].delete();
        end
        pressT[0] = 0; pressT[1] = 0;
        expL = 0; expR = 0; expF = 0;
    endfunction

    function automatic void modelStep();
        bit raw [3];
        bit newLvl [3];
        bit rise [3];
        bit rep [2];
        bit allDiff;
        int d;
        raw[0] = btnL_in; raw[1] = btnR_in; raw[2] = btnU_in;
        for (int i = 0; i < 3; i++) begin
            hist[i].push_back(s2[i]);
            if (hist[i].size() > DEB) void'(hist[i].pop_front());
            newLvl[i] = lvl[i];
            if (hist[i].size() == DEB) begin
                allDiff = 1;
                for (int k = 0; k < hist[i].size(); k++)
                    if (hist[i][k] == lvl[i]) allDiff = 0;
                if (allDiff) newLvl[i] = !lvl[i];
            end
            s2[i] = s1[i];
            s1[i] = raw[i];
            rise[i] = newLvl[i] && !lvl[i];
        end
        for (int i = 0; i < 2; i++) begin
            rep[i] = 0;
            if (rise[i]) pressT[i] = cyc;
            if (lvl[i] && newLvl[i]) begin
                d = cyc - pressT[i];
                rep[i] = (d == RDELAY) || (d > RDELAY && ((d - RDELAY) % RPERIOD) == 0);
            end
        end
        expL = (rise[0] || rep[0]) && newLvl[0] && !newLvl[1] && !newLvl[2];
        expR = (rise[1] || rep[1]) && newLvl[1] && !newLvl[0] && !newLvl[2];
        expF = rise[2] && !newLvl[0] && !newLvl[1];
        for (int i = 0; i < 3; i++) lvl[i] = newLvl[i];
        cyc++;
    endfunction

    function automatic logic [5:0] dutVec();
        return {left_level, right_level, fire_level, left_move, right_move, fire};
    endfunction

    function automatic logic [5:0] expVec();
        return {lvl[0], lvl[1], lvl[2], expL, expR, expF};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic stepCycle();
        @(posedge clk);
        if (reset) modelReset();
        else modelStep();
        @(negedge clk);
        check("cycle outputs {lL,lR,lU,mL,mR,f}", int'(dutVec()), int'(expVec()));
        check("at most one action", int'($countones({left_move, right_move, fire}) <= 1), 1);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #1;
        check("reset clears outputs at once", int'(dutVec()), 0);
        modelReset();
        stepCycle();
        reset = 1'b0;
    endtask

    task automatic setBtns(input bit l, input bit r, input bit u);
        btnL_in = l; btnR_in = r; btnU_in = u;
    endtask

    typedef struct {
        bit l, r, u;
        int cycles;
        bit eL, eR, eU;
        int nL, nR, nF;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cntL, cntR, cntF, lvlHigh;
        int pulseIdx [$];
        int hold [3];
        bit v;

        // row: inputs, cycles, expected end levels, expected pulse counts
        vecs[0] = '{0,0,1, 30, 0,0,1, 0,0,1};  // clean fire press
        vecs[1] = '{0,0,0, 10, 0,0,0, 0,0,0};  // fire release
        vecs[2] = '{0,1,0, 45, 0,1,0, 0,7,0};  // press + 6 repeats
        vecs[3] = '{0,0,0, 10, 0,0,0, 0,1,0};  // repeat before level falls, none on release
        vecs[4] = '{1,0,0,  3, 0,0,0, 0,0,0};  // left still debouncing
        vecs[5] = '{1,0,1, 20, 1,0,1, 1,0,0};  // fire blocked, left repeats blocked
        vecs[6] = '{0,0,1, 10, 0,0,1, 0,0,0};  // left released while fire held
        vecs[7] = '{0,0,0, 10, 0,0,0, 0,0,0};
        vecs[8] = '{1,1,0, 20, 1,1,0, 0,0,0};  // simultaneous L/R acceptance
        vecs[9] = '{0,0,0, 10, 0,0,0, 0,0,0};

        cyc = 0;
        reset = 1'b1;
        setBtns(0, 0, 0);
        modelReset();
        repeat (3) stepCycle();
        check("reset state", int'(dutVec()), 0);
        reset = 1'b0;

        for (int v_i = 0; v_i < 10; v_i++) begin
            setBtns(vecs[v_i].l, vecs[v_i].r, vecs[v_i].u);
            cntL = 0; cntR = 0; cntF = 0;
            for (int c = 0; c < vecs[v_i].cycles; c++) begin
                stepCycle();
                cntL += int'(left_move);
                cntR += int'(right_move);
                cntF += int'(fire);
            end
            check($sformatf("row%0d levels", v_i), int'({left_level, right_level, fire_level}),
                  int'({vecs[v_i].eL, vecs[v_i].eR, vecs[v_i].eU}));
            check($sformatf("row%0d left pulses", v_i), cntL, vecs[v_i].nL);
            check($sformatf("row%0d right pulses", v_i), cntR, vecs[v_i].nR);
            check($sformatf("row%0d fire pulses", v_i), cntF, vecs[v_i].nF);
        end

        // Bounce: 2-high/2-low toggling must never be accepted.
        lvlHigh = 0; cntL = 0;
        for (int c = 0; c < 26; c++) begin
            btnL_in = (c < 20) && ((c % 4) < 2);
            stepCycle();
            lvlHigh += int'(left_level);
            cntL += int'(left_move);
        end
        check("bounce left_level highs", lvlHigh, 0);
        check("bounce left_move pulses", cntL, 0);
        btnL_in = 1'b1;
        cntL = 0;
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            if (c < 6) cntL += int'(left_move | left_level);
        end
        check("stable press early activity", cntL, 0);
        check("stable press level at +6", int'(left_level), 1);
        check("stable press pulse at +6", int'(left_move), 1);
        btnL_in = 1'b0;
        repeat (12) stepCycle();

        // Reset while right is held and repeating.
        btnR_in = 1'b1;
        repeat (21) stepCycle();
        check("right held before reset", int'(right_level), 1);
        pulseReset();
        for (int c = 1; c <= 20; c++) begin
            stepCycle();
            if (c == 5) check("right level low at +5 after reset", int'(right_level), 0);
            if (c == 6) check("right level high at +6 after reset", int'(right_level), 1);
            if (right_move) pulseIdx.push_back(c);
        end
        check("post-reset pulse count", pulseIdx.size(), 2);
        if (pulseIdx.size() == 2) begin
            check("post-reset press pulse cycle", pulseIdx[0], 6);
            check("post-reset first repeat cycle", pulseIdx[1], 6 + RDELAY);
        end
        btnR_in = 1'b0;
        repeat (12) stepCycle();

        // Randomized holds, glitches and occasional resets.
        hold[0] = 0; hold[1] = 0; hold[2] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    v = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3)
                                                          : $urandom_range(5, 40);
                    case (i)
                        0: btnL_in = v;
                        1: btnR_in = v;
                        default: btnU_in = v;
                    endcase
                end
                hold[i]--;
            end
            if ($urandom_range(0, 399) == 0) pulseReset();
            else stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
